uart_tx_serializer: RTL and testbench

UART transmit path; the counterpart of the UART_RX receiver (deserializer, edge counter, Parity_Check). Accepts a parallel byte with a one-cycle valid strobe and serializes it on TX_OUT as start bit, data LSB-first, optional parity, and stop bit. Each bit is held for Prescale clk cycles, so the same Prescale value drives TX and RX at a matched baud rate. Sits beside UART_RX under the UART top.

---
 rtl/uart_tx_serializer.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// UART transmit serializer. Accepts a parallel word with a one-cycle
// Data_Valid strobe while idle and sends it on TX_OUT in this order:
//   start bit (0), data LSB first, optional parity, stop bit (1).
// Each bit is held for Prescale clk cycles. A Prescale of 0 is treated as 1.
// The same Prescale value gives a baud rate that matches the UART_RX receiver.
//
// Optional build macro:
//   UART_TX_TWO_STOP_EN - when defined, the frame ends with two stop bits
//                         (the STOP state lasts 2*P cycles).
//
// Ports:
//   clk         in   system clock; all logic on posedge
//   reset       in   synchronous active-high reset
//   P_DATA      in   [DATA_width-1:0] word to transmit
//   Data_Valid  in   one-cycle request; accepted only while busy=0
//   PAR_EN      in   1 = parity bit included in the frame
//   PAR_TYP     in   0 = even parity, 1 = odd parity
//   Prescale    in   [Prescale_width-1:0] clk cycles per bit
//   TX_OUT      out  serial line, idle high, registered
//   busy        out  high while a frame is in progress, registered
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_width     = 8,
  parameter int Prescale_width = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_width-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [Prescale_width-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      busy
);

  localparam int IDX_W = (DATA_width > 1) ? $clog2(DATA_width) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                    state_q, state_d;
  logic [Prescale_width-1:0] cnt_q, cnt_d;
  logic [Prescale_width-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [DATA_width-1:0]     data_q, data_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
`ifdef UART_TX_TWO_STOP_EN
  logic                      stop2_q, stop2_d;  // second stop bit in progress
`endif

  logic             bit_last;
  logic [IDX_W-1:0] idx_next;

  // presc_q is never 0 while a frame runs, so P-1 does not underflow.
  assign bit_last = (cnt_q == presc_q - Prescale_width'(1));
  assign idx_next = idx_q + IDX_W'(1);

  // The line value is computed one cycle early so that TX_OUT is registered
  // and changes on the same edge as the state does.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
`ifdef UART_TX_TWO_STOP_EN
    stop2_d   = stop2_q;
`endif

    if (state_q != IDLE) begin
      cnt_d = bit_last ? '0 : cnt_q + Prescale_width'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (Data_Valid) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          presc_d   = (Prescale == '0) ? Prescale_width'(1) : Prescale;
          idx_d     = '0;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
          stop2_d   = 1'b0;
`endif
        end
      end

      START: begin
        if (bit_last) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end

      DATA: begin
        if (bit_last) begin
          if (idx_q == IDX_W'(DATA_width - 1)) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = (^data_q) ^ par_typ_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_next;
            tx_d  = data_q[idx_next];
          end
        end
      end

      PARITY: begin
        if (bit_last) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end

      STOP: begin
        if (bit_last) begin
`ifdef UART_TX_TWO_STOP_EN
          if (!stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            stop2_d = 1'b0;
            state_d = IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
          tx_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      presc_q   <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= stop2_d;
`endif
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Directed testbench for uart_tx_serializer. Frames are written as hand-built
// bit strings in line order (first bit on the left). Every clk cycle of a frame
// is checked for TX_OUT and busy, followed by the idle state right after the
// frame. With UART_TX_TWO_STOP_EN defined, one extra stop bit is expected.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       busy;

  int tests  = 0;
  int failed = 0;

`ifdef UART_TX_TWO_STOP_EN
  localparam int XS = 1;
`else
  localparam int XS = 0;
`endif

  uart_tx_serializer #(
    .DATA_width    (8),
    .Prescale_width(6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .TX_OUT    (TX_OUT),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv)
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Called at a negedge; the request is sampled on the following posedge.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic [5:0] ps);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = ps;
    Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
  endtask

  // Checks n bits of exp (MSB first = first on the line), each held p cycles,
  // plus XS extra stop bits, then the idle line one cycle after busy falls.
  // At frame cycle inject_at a new request with different settings is issued.
  task automatic check_frame(input string tag, input logic [15:0] exp,
                             input int n, input int p, input int inject_at);
    int   total;
    int   cyc;
    logic b;
    total = n + XS;
    cyc   = 0;
    for (int i = 0; i < total; i++) begin
      b = (i < n) ? exp[n-1-i] : 1'b1;
      for (int c = 0; c < p; c++) begin
        chk({tag, " tx"}, TX_OUT, b);
        chk({tag, " busy"}, busy, 1'b1);
        if (cyc == inject_at) begin
          P_DATA     = 8'hFF;
          PAR_EN     = ~PAR_EN;
          Prescale   = 6'd2;
          Data_Valid = 1'b1;
        end else begin
          Data_Valid = 1'b0;
        end
        cyc++;
        @(negedge clk);
      end
    end
    Data_Valid = 1'b0;
    chk({tag, " end tx"}, TX_OUT, 1'b1);
    chk({tag, " end busy"}, busy, 1'b0);
    $display("[TB] frame %s: %0d bits x %0d cycles, busy %0d cycles", tag, total, p, total * p);
  endtask

  task automatic check_idle(input string tag, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      chk({tag, " idle tx"}, TX_OUT, 1'b1);
      chk({tag, " idle busy"}, busy, 1'b0);
    end
    $display("[TB] idle %s: %0d cycles", tag, ncyc);
  endtask

  initial begin
    reset      = 1'b1;
    Data_Valid = 1'b0;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset tx", TX_OUT, 1'b1);
    chk("reset busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset tx", TX_OUT, 1'b1);
    chk("post-reset busy", busy, 1'b0);
    $display("[TB] reset checked");

    // B2, even parity, P=8: 0 | 0,1,0,0,1,1,0,1 | 0 | 1 -> 88 cycles busy
    send(8'hB2, 1'b1, 1'b0, 6'd8);
    check_frame("b2_even", 16'b00100110101, 11, 8, -1);

    // B2, odd parity: parity bit becomes 1
    send(8'hB2, 1'b1, 1'b1, 6'd8);
    check_frame("b2_odd", 16'b00100110111, 11, 8, -1);

    // 00, odd parity: parity bit 1
    send(8'h00, 1'b1, 1'b1, 6'd8);
    check_frame("00_odd", 16'b00000000011, 11, 8, -1);

    // 5A, no parity, P=4: 0 | 0,1,0,1,1,0,1,0 | 1 -> 40 cycles busy
    send(8'h5A, 1'b0, 1'b0, 6'd4);
    check_frame("5a_nopar", 16'b0010110101, 10, 4, -1);

    // Request and config changes while busy are ignored and not queued
    send(8'hB2, 1'b1, 1'b0, 6'd8);
    check_frame("b2_ignored_req", 16'b00100110101, 11, 8, 20);
    check_idle("no_second_frame", 20);

    // Back-to-back: next request one cycle after busy falls starts at once
    send(8'h5A, 1'b0, 1'b0, 6'd4);
    check_frame("5a_first", 16'b0010110101, 10, 4, -1);
    send(8'hB2, 1'b1, 1'b1, 6'd3);
    check_frame("b2_back_to_back", 16'b00100110111, 11, 3, -1);

    // Reset during DATA bit 3 (frame cycles 32..39) abandons the frame
    send(8'hB2, 1'b1, 1'b0, 6'd8);
    repeat (34) @(negedge clk);
    chk("midframe bit3 tx", TX_OUT, 1'b0);
    chk("midframe bit3 busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midframe reset tx", TX_OUT, 1'b1);
    chk("midframe reset busy", busy, 1'b0);
    reset = 1'b0;
    check_idle("after_midframe_reset", 16);

    // Prescale=0 acts as 1: each bit lasts one cycle, busy 11 cycles
    send(8'hB2, 1'b1, 1'b0, 6'd0);
    check_frame("b2_presc0", 16'b00100110101, 11, 1, -1);
    check_idle("after_presc0", 4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
